// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared seven-segment encodings and digit-slot indices for the
//             stopwatch display scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit slot indices, rightmost digit first
  localparam logic [1:0] DIG_TENTHS = 2'd0;
  localparam logic [1:0] DIG_ONES   = 2'd1;
  localparam logic [1:0] DIG_TENS   = 2'd2;
  localparam logic [1:0] DIG_MIN    = 2'd3;

  typedef logic [3:0] bcd_t;

  // One captured frame of the stopwatch digit bus
  typedef struct packed {
    bcd_t minutes;
    bcd_t tens;
    bcd_t ones;
    bcd_t tenths;
  } snap_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_display_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_display_scan_if
//  Purpose  : Stopwatch BCD digit bus. The stopwatch drives it (master), the
//             display scanner consumes it (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_display_scan_if;
  import seg7_pkg::*;

  bcd_t Tenths_Seconds;
  bcd_t Ones_Seconds;
  bcd_t Tens_Seconds;
  bcd_t Minutes;

  modport master (output Tenths_Seconds, output Ones_Seconds,
                  output Tens_Seconds,   output Minutes);
  modport slave  (input  Tenths_Seconds, input  Ones_Seconds,
                  input  Tens_Seconds,   input  Minutes);

endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD to active-low seven-segment decoder. Codes
//             10..15 decode to a dash so corrupt digits stay visible.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup; anything outside 0..9 shows a dash
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_display_scan
//  Purpose  : Snapshots the four stopwatch digits once per frame and scans
//             them onto a 4-digit common-anode display (M SS.t) with dead
//             time between slots and leading-zero blanking. All outputs are
//             registered.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_display_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV      = 4,     // clocks per digit slot, 2..65535
  parameter int DEAD_CYCLES   = 1,     // anode-off clocks at slot start, < SCAN_DIV
  parameter bit BLANK_LEADING = 1'b1   // blank leading zeros of M and tens
) (
  input  logic                     clk,
  input  logic                     reset,       // asynchronous, active-low
  stopwatch_display_scan_if.slave  digits,
  output logic [6:0]               Seg,
  output logic                     Dp,
  output logic [3:0]               An,
  output logic                     Frame_Start
);

  localparam logic [15:0] c_cnt_last = 16'(SCAN_DIV - 1);
  localparam logic [15:0] c_dead     = 16'(DEAD_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  snap_t       snap_q, snap_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        fs_q, fs_d;

  logic        w_slot_end;
  logic        w_frame_end;
  bcd_t        w_digit;
  logic [6:0]  w_seg_dec;
  logic        w_blank;

  assign w_slot_end  = (cnt_q == c_cnt_last);
  assign w_frame_end = w_slot_end && (idx_q == DIG_MIN);

  // Slot/digit counters and frame snapshot; inputs only enter at frame end
  always_comb begin
    cnt_d  = w_slot_end ? 16'd0 : cnt_q + 16'd1;
    idx_d  = w_slot_end ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    if (w_frame_end) begin
      snap_d = {digits.Minutes, digits.Tens_Seconds,
                digits.Ones_Seconds, digits.Tenths_Seconds};
    end
  end

  // Select the snapshot digit for the current slot
  always_comb begin
    w_digit = snap_q.tenths;
    case (idx_q)
      DIG_TENTHS: w_digit = snap_q.tenths;
      DIG_ONES:   w_digit = snap_q.ones;
      DIG_TENS:   w_digit = snap_q.tens;
      DIG_MIN:    w_digit = snap_q.minutes;
      default:    w_digit = snap_q.tenths;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (w_digit),
    .seg_o (w_seg_dec)
  );

  // Leading-zero blanking, anode dead time and decimal point placement
  always_comb begin
    w_blank = BLANK_LEADING &&
              (((idx_q == DIG_MIN)  && (snap_q.minutes == 4'd0)) ||
               ((idx_q == DIG_TENS) && (snap_q.minutes == 4'd0) &&
                (snap_q.tens == 4'd0)));
    seg_d = w_blank ? SEG_BLANK : w_seg_dec;
    dp_d  = (idx_q != DIG_ONES);
    an_d  = (cnt_q >= c_dead) ? ~(4'b0001 << idx_q) : 4'b1111;
    fs_d  = w_frame_end;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 16'd0;
      idx_q  <= 2'd0;
      snap_q <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= 4'b1111;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fs_q   <= fs_d;
    end
  end

  assign Seg         = seg_q;
  assign Dp          = dp_q;
  assign An          = an_q;
  assign Frame_Start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_display_scan
//  Purpose  : Self-checking bench for stopwatch_display_scan. Outputs are
//             predicted from the elapsed cycle count since reset release and
//             a model snapshot of the digit bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_scan;

  localparam int SCAN_DIV    = 4;
  localparam int DEAD_CYCLES = 1;
  localparam int FRAME       = 4 * SCAN_DIV;
  localparam logic [6:0] DIGIT_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Seg;
  logic       Dp;
  logic [3:0] An;
  logic       Frame_Start;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k;              // rising edges since reset release
  logic [3:0] m_snap [4];     // model snapshot, index = digit position

  stopwatch_display_scan_if bus ();

  stopwatch_display_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEAD_CYCLES   (DEAD_CYCLES),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (bus.slave),
    .Seg         (Seg),
    .Dp          (Dp),
    .An          (An),
    .Frame_Start (Frame_Start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_digits(input logic [3:0] m, input logic [3:0] tn,
                            input logic [3:0] on, input logic [3:0] te);
    bus.Minutes        = m;
    bus.Tens_Seconds   = tn;
    bus.Ones_Seconds   = on;
    bus.Tenths_Seconds = te;
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 3) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  // What the display should show for a digit position given the model snapshot
  function automatic logic [6:0] model_seg(input int slot);
    logic [3:0] v;
    v = m_snap[slot];
    if (slot == 3 && m_snap[3] == 4'd0) return 7'h7F;
    if (slot == 2 && m_snap[3] == 4'd0 && m_snap[2] == 4'd0) return 7'h7F;
    if (v > 4'd9) return 7'h3F;
    return DIGIT_SEG[v];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq($sformatf("%s_an", tag),  32'(An),          32'h0F);
    check_eq($sformatf("%s_seg", tag), 32'(Seg),         32'h7F);
    check_eq($sformatf("%s_dp", tag),  32'(Dp),          32'h1);
    check_eq($sformatf("%s_fs", tag),  32'(Frame_Start), 32'h0);
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
  endtask

  // Advance one clock, then compare against the cycle-count model
  task automatic step_and_check(input string tag);
    int         pos;
    int         slot;
    int         c;
    logic [3:0] exp_an;
    @(posedge clk);
    @(negedge clk);
    k++;
    pos    = (k - 1) % FRAME;
    slot   = pos / SCAN_DIV;
    c      = pos % SCAN_DIV;
    exp_an = (c >= DEAD_CYCLES) ? ~(4'b0001 << slot) : 4'b1111;
    check_eq($sformatf("%s_an", tag),  32'(An),          32'(exp_an));
    check_eq($sformatf("%s_seg", tag), 32'(Seg),         32'(model_seg(slot)));
    check_eq($sformatf("%s_dp", tag),  32'(Dp),          (slot == 1) ? 32'h0 : 32'h1);
    check_eq($sformatf("%s_fs", tag),  32'(Frame_Start), (pos == FRAME - 1) ? 32'h1 : 32'h0);
    if (pos == FRAME - 1) begin
      m_snap[0] = bus.Tenths_Seconds;
      m_snap[1] = bus.Ones_Seconds;
      m_snap[2] = bus.Tens_Seconds;
      m_snap[3] = bus.Minutes;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    reset = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();

    // Reset held: outputs stay at their reset values
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    reset = 1'b1;
    model_reset();
    check_reset_outputs("rst_rel");

    // 1:23.4 (first frame shows the cleared snapshot)
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 2 * FRAME; i++) step_and_check("d1234");

    // 0:05.7 with leading blanking
    set_digits(4'd0, 4'd0, 4'd5, 4'd7);
    for (int i = 0; i < 2 * FRAME; i++) step_and_check("d0057");

    // Ones changes while slot 1 is on screen; no tearing
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < FRAME; i++) step_and_check("pre_tear");
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      step_and_check("seek_idx1");
      if ((k % FRAME) / SCAN_DIV == 1) found = 1'b1;
    end
    check_eq("reach_idx1", 32'(found), 32'h1);
    bus.Ones_Seconds = 4'd8;
    for (int i = 0; i < 2 * FRAME; i++) step_and_check("tear");

    // Invalid tenths shows a dash
    set_digits(4'd1, 4'd2, 4'd3, 4'hC);
    for (int i = 0; i < 2 * FRAME; i++) step_and_check("dash");

    // Random digit traffic, changing at arbitrary points in the frame
    for (int i = 0; i < 400; i++) begin
      step_and_check("rand");
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.Tenths_Seconds = rand_digit();
          1:       bus.Ones_Seconds   = rand_digit();
          2:       bus.Tens_Seconds   = rand_digit();
          default: bus.Minutes        = rand_digit();
        endcase
      end
    end

    // Asynchronous reset in the middle of slot 2 while its anode is lit
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step_and_check("seek_idx2");
      if ((k % FRAME) / SCAN_DIV == 2 && (k % SCAN_DIV) == 2) found = 1'b1;
    end
    check_eq("reach_idx2", 32'(found), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("async_hold");
    reset = 1'b1;
    model_reset();
    set_digits(4'd3, 4'd0, 4'd9, 4'd1);
    for (int i = 0; i < 3 * FRAME; i++) step_and_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
